// File: rtl/mem_bus_arbiter_pkg.sv
// Shared memory-bus definitions: bus widths, arbitration modes, arbiter FSM
// state encoding and the peripheral request payload.
package mem_bus_arbiter_pkg;

  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned WORD_W      = 32;
  localparam int unsigned MEM_COUNT_W = 3;
  localparam int unsigned MEM_CODE_W  = 2;

  localparam int unsigned PRIO_RR    = 0;
  localparam int unsigned PRIO_FIXED = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0]      addr;
    logic [WORD_W-1:0]      wr_data;
    logic                   wr_en;
    logic [MEM_COUNT_W-1:0] count;
  } mem_req_t;

endpackage

// File: rtl/mem_bus_arbiter_rr_arbiter_2.sv
// Two-port combinational grant logic.
// Ports: i_valid (request per port), i_last_grant (port granted last),
//        i_fixed (1 = port 0 always wins ties), o_grant_c (one-hot grant).
module rr_arbiter_2 (
  input  logic [1:0] i_valid,
  input  logic       i_last_grant,
  input  logic       i_fixed,
  output logic [1:0] o_grant_c
);

  always_comb begin
    o_grant_c = 2'b00;
    if (i_fixed) begin
      o_grant_c[0] = i_valid[0];
      o_grant_c[1] = i_valid[1] & ~i_valid[0];
    end else if (&i_valid) begin
      // Tie: hand the bus to the port that did not win last time.
      o_grant_c = i_last_grant ? 2'b01 : 2'b10;
    end else begin
      o_grant_c = i_valid;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-requester memory bus arbiter: IDLE -> ISSUE (one cycle on the shared
// request bus) -> RESP (one-cycle response pulse to the winner).
// Ports: clk/aresetn; per requester N: i_pN_valid/addr/wr_data/wr_en/count in,
//        o_pN_ready, o_pN_res_valid/rd_data/code out; shared o_req_* bus out,
//        i_res_rd_data/i_res_code in (combinational from the peripheral).
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned PRIO_MODE = PRIO_RR
) (
  input  logic                   clk,
  input  logic                   aresetn,
  input  logic                   i_p0_valid,
  input  logic [ADDR_W-1:0]      i_p0_addr,
  input  logic [WORD_W-1:0]      i_p0_wr_data,
  input  logic                   i_p0_wr_en,
  input  logic [MEM_COUNT_W-1:0] i_p0_count,
  output logic                   o_p0_ready,
  output logic                   o_p0_res_valid,
  output logic [WORD_W-1:0]      o_p0_res_rd_data,
  output logic [MEM_CODE_W-1:0]  o_p0_res_code,
  input  logic                   i_p1_valid,
  input  logic [ADDR_W-1:0]      i_p1_addr,
  input  logic [WORD_W-1:0]      i_p1_wr_data,
  input  logic                   i_p1_wr_en,
  input  logic [MEM_COUNT_W-1:0] i_p1_count,
  output logic                   o_p1_ready,
  output logic                   o_p1_res_valid,
  output logic [WORD_W-1:0]      o_p1_res_rd_data,
  output logic [MEM_CODE_W-1:0]  o_p1_res_code,
  output logic [ADDR_W-1:0]      o_req_addr,
  output logic [WORD_W-1:0]      o_req_wr_data,
  output logic                   o_req_wr_en,
  output logic [MEM_COUNT_W-1:0] o_req_count,
  input  logic [WORD_W-1:0]      i_res_rd_data,
  input  logic [MEM_CODE_W-1:0]  i_res_code
);

  localparam logic FIXED = (PRIO_MODE == PRIO_FIXED);

  state_e                r_state, w_state_nxt;
  mem_req_t              r_req, w_req_nxt;
  logic [1:0]            r_ready, w_ready_nxt;
  logic [1:0]            r_res_valid, w_res_valid_nxt;
  logic                  r_winner, w_winner_nxt;
  logic                  r_last, w_last_nxt;
  logic [WORD_W-1:0]     r_p0_rd, w_p0_rd_nxt, r_p1_rd, w_p1_rd_nxt;
  logic [MEM_CODE_W-1:0] r_p0_code, w_p0_code_nxt, r_p1_code, w_p1_code_nxt;
  mem_req_t              w_p0_req, w_p1_req;
  logic [1:0]            w_grant;

  always_comb begin
    w_p0_req.addr    = i_p0_addr;
    w_p0_req.wr_data = i_p0_wr_data;
    w_p0_req.wr_en   = i_p0_wr_en;
    w_p0_req.count   = i_p0_count;
    w_p1_req.addr    = i_p1_addr;
    w_p1_req.wr_data = i_p1_wr_data;
    w_p1_req.wr_en   = i_p1_wr_en;
    w_p1_req.count   = i_p1_count;
  end

  rr_arbiter_2 u_arb (
    .i_valid      ({i_p1_valid, i_p0_valid}),
    .i_last_grant (r_last),
    .i_fixed      (FIXED),
    .o_grant_c    (w_grant)
  );

  // Next-state and next-output logic; the request bus defaults to zero so it
  // is only non-zero during ISSUE.
  always_comb begin
    w_state_nxt     = r_state;
    w_req_nxt       = '0;
    w_ready_nxt     = 2'b00;
    w_res_valid_nxt = 2'b00;
    w_winner_nxt    = r_winner;
    w_last_nxt      = r_last;
    w_p0_rd_nxt     = r_p0_rd;
    w_p0_code_nxt   = r_p0_code;
    w_p1_rd_nxt     = r_p1_rd;
    w_p1_code_nxt   = r_p1_code;
    case (r_state)
      ST_IDLE, ST_RESP: begin
        if (|w_grant) begin
          w_state_nxt  = ST_ISSUE;
          w_req_nxt    = w_grant[1] ? w_p1_req : w_p0_req;
          w_ready_nxt  = w_grant;
          w_winner_nxt = w_grant[1];
          w_last_nxt   = w_grant[1];
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        // Peripheral response is captured at the edge closing ISSUE.
        w_state_nxt = ST_RESP;
        if (r_winner) begin
          w_res_valid_nxt = 2'b10;
          w_p1_rd_nxt     = i_res_rd_data;
          w_p1_code_nxt   = i_res_code;
        end else begin
          w_res_valid_nxt = 2'b01;
          w_p0_rd_nxt     = i_res_rd_data;
          w_p0_code_nxt   = i_res_code;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State and registered outputs; pointer resets to port 1 so port 0 wins the first tie.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_state     <= ST_IDLE;
      r_req       <= '0;
      r_ready     <= 2'b00;
      r_res_valid <= 2'b00;
      r_winner    <= 1'b0;
      r_last      <= 1'b1;
      r_p0_rd     <= '0;
      r_p0_code   <= '0;
      r_p1_rd     <= '0;
      r_p1_code   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_req       <= w_req_nxt;
      r_ready     <= w_ready_nxt;
      r_res_valid <= w_res_valid_nxt;
      r_winner    <= w_winner_nxt;
      r_last      <= w_last_nxt;
      r_p0_rd     <= w_p0_rd_nxt;
      r_p0_code   <= w_p0_code_nxt;
      r_p1_rd     <= w_p1_rd_nxt;
      r_p1_code   <= w_p1_code_nxt;
    end
  end

  assign o_p0_ready       = r_ready[0];
  assign o_p1_ready       = r_ready[1];
  assign o_p0_res_valid   = r_res_valid[0];
  assign o_p1_res_valid   = r_res_valid[1];
  assign o_p0_res_rd_data = r_p0_rd;
  assign o_p0_res_code    = r_p0_code;
  assign o_p1_res_rd_data = r_p1_rd;
  assign o_p1_res_code    = r_p1_code;
  assign o_req_addr       = r_req.addr;
  assign o_req_wr_data    = r_req.wr_data;
  assign o_req_wr_en      = r_req.wr_en;
  assign o_req_count      = r_req.count;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a round-robin and a fixed-priority
// instance share the same stimulus.
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  logic clk = 1'b0;
  logic aresetn = 1'b0;
  logic                   p0_valid, p0_wr_en, p1_valid, p1_wr_en;
  logic [ADDR_W-1:0]      p0_addr, p1_addr;
  logic [WORD_W-1:0]      p0_wr_data, p1_wr_data, res_rd_data;
  logic [MEM_COUNT_W-1:0] p0_count, p1_count;
  logic [MEM_CODE_W-1:0]  res_code;

  logic                   rr_p0_ready, rr_p0_res_valid, rr_p1_ready, rr_p1_res_valid, rr_req_wr_en;
  logic [WORD_W-1:0]      rr_p0_res_rd_data, rr_p1_res_rd_data, rr_req_wr_data;
  logic [MEM_CODE_W-1:0]  rr_p0_res_code, rr_p1_res_code;
  logic [ADDR_W-1:0]      rr_req_addr;
  logic [MEM_COUNT_W-1:0] rr_req_count;

  logic                   fx_p0_ready, fx_p0_res_valid, fx_p1_ready, fx_p1_res_valid, fx_req_wr_en;
  logic [WORD_W-1:0]      fx_p0_res_rd_data, fx_p1_res_rd_data, fx_req_wr_data;
  logic [MEM_CODE_W-1:0]  fx_p0_res_code, fx_p1_res_code;
  logic [ADDR_W-1:0]      fx_req_addr;
  logic [MEM_COUNT_W-1:0] fx_req_count;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.PRIO_MODE(0)) u_rr (
    .clk(clk), .aresetn(aresetn),
    .i_p0_valid(p0_valid), .i_p0_addr(p0_addr), .i_p0_wr_data(p0_wr_data),
    .i_p0_wr_en(p0_wr_en), .i_p0_count(p0_count),
    .o_p0_ready(rr_p0_ready), .o_p0_res_valid(rr_p0_res_valid),
    .o_p0_res_rd_data(rr_p0_res_rd_data), .o_p0_res_code(rr_p0_res_code),
    .i_p1_valid(p1_valid), .i_p1_addr(p1_addr), .i_p1_wr_data(p1_wr_data),
    .i_p1_wr_en(p1_wr_en), .i_p1_count(p1_count),
    .o_p1_ready(rr_p1_ready), .o_p1_res_valid(rr_p1_res_valid),
    .o_p1_res_rd_data(rr_p1_res_rd_data), .o_p1_res_code(rr_p1_res_code),
    .o_req_addr(rr_req_addr), .o_req_wr_data(rr_req_wr_data),
    .o_req_wr_en(rr_req_wr_en), .o_req_count(rr_req_count),
    .i_res_rd_data(res_rd_data), .i_res_code(res_code)
  );

  mem_bus_arbiter #(.PRIO_MODE(1)) u_fx (
    .clk(clk), .aresetn(aresetn),
    .i_p0_valid(p0_valid), .i_p0_addr(p0_addr), .i_p0_wr_data(p0_wr_data),
    .i_p0_wr_en(p0_wr_en), .i_p0_count(p0_count),
    .o_p0_ready(fx_p0_ready), .o_p0_res_valid(fx_p0_res_valid),
    .o_p0_res_rd_data(fx_p0_res_rd_data), .o_p0_res_code(fx_p0_res_code),
    .i_p1_valid(p1_valid), .i_p1_addr(p1_addr), .i_p1_wr_data(p1_wr_data),
    .i_p1_wr_en(p1_wr_en), .i_p1_count(p1_count),
    .o_p1_ready(fx_p1_ready), .o_p1_res_valid(fx_p1_res_valid),
    .o_p1_res_rd_data(fx_p1_res_rd_data), .o_p1_res_code(fx_p1_res_code),
    .o_req_addr(fx_req_addr), .o_req_wr_data(fx_req_wr_data),
    .o_req_wr_en(fx_req_wr_en), .o_req_count(fx_req_count),
    .i_res_rd_data(res_rd_data), .i_res_code(res_code)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    tick();
    tick();
    aresetn = 1'b1;
  endtask

  task automatic test_reset();
    p0_valid = 0; p0_addr = '0; p0_wr_data = '0; p0_wr_en = 0; p0_count = '0;
    p1_valid = 0; p1_addr = '0; p1_wr_data = '0; p1_wr_en = 0; p1_count = '0;
    res_rd_data = '0; res_code = '0;
    aresetn = 1'b0;
    #3;
    n_total++; if ({rr_p0_ready, rr_p1_ready, rr_p0_res_valid, rr_p1_res_valid} !== 4'b0) $display("FAIL reset_pulses: got %b want 0000", {rr_p0_ready, rr_p1_ready, rr_p0_res_valid, rr_p1_res_valid}); else n_pass++;
    n_total++; if ({rr_req_addr, rr_req_wr_data, rr_req_wr_en, rr_req_count} !== '0) $display("FAIL reset_bus: got addr %0h data %0h we %0b", rr_req_addr, rr_req_wr_data, rr_req_wr_en); else n_pass++;
    n_total++; if ({rr_p0_res_rd_data, rr_p0_res_code, rr_p1_res_rd_data, rr_p1_res_code} !== '0) $display("FAIL reset_resdata: got p0 %0h p1 %0h want 0", rr_p0_res_rd_data, rr_p1_res_rd_data); else n_pass++;
    tick();
    aresetn = 1'b1;
    tick();
  endtask

  // Single port-0 write: ready/wr_en in E+1, res_valid in E+2.
  task automatic test_write();
    p0_valid = 1; p0_addr = 32'h0000_0008; p0_wr_data = 32'hDEAD_BEEF; p0_wr_en = 1; p0_count = 3'd2;
    tick();
    n_total++; if (rr_p0_ready !== 1'b1) $display("FAIL wr_ready0: got %0b want 1", rr_p0_ready); else n_pass++;
    n_total++; if (rr_p1_ready !== 1'b0) $display("FAIL wr_ready1: got %0b want 0", rr_p1_ready); else n_pass++;
    n_total++; if (rr_req_wr_en !== 1'b1) $display("FAIL wr_we_issue: got %0b want 1", rr_req_wr_en); else n_pass++;
    n_total++; if (rr_req_addr !== 32'h8) $display("FAIL wr_addr: got %0h want 8", rr_req_addr); else n_pass++;
    n_total++; if (rr_req_wr_data !== 32'hDEAD_BEEF) $display("FAIL wr_data: got %0h want deadbeef", rr_req_wr_data); else n_pass++;
    n_total++; if (rr_req_count !== 3'd2) $display("FAIL wr_count: got %0d want 2", rr_req_count); else n_pass++;
    n_total++; if (rr_p0_res_valid !== 1'b0) $display("FAIL wr_early_resv: got %0b want 0", rr_p0_res_valid); else n_pass++;
    p0_valid = 0; p0_wr_en = 0;
    res_rd_data = 32'h0; res_code = 2'd0;
    tick();
    n_total++; if (rr_p0_res_valid !== 1'b1) $display("FAIL wr_resv: got %0b want 1", rr_p0_res_valid); else n_pass++;
    n_total++; if ({rr_req_wr_en, rr_req_addr} !== '0) $display("FAIL wr_bus_resp: got we %0b addr %0h want 0", rr_req_wr_en, rr_req_addr); else n_pass++;
    n_total++; if (rr_p0_ready !== 1'b0) $display("FAIL wr_ready_pulse: got %0b want 0", rr_p0_ready); else n_pass++;
    tick();
    n_total++; if (rr_p0_res_valid !== 1'b0) $display("FAIL wr_resv_pulse: got %0b want 0", rr_p0_res_valid); else n_pass++;
  endtask

  // Simultaneous reads after reset: port 0 first, port 1 two cycles later.
  task automatic test_both_read();
    do_reset();
    p0_valid = 1; p0_addr = 32'h10; p0_wr_en = 0;
    p1_valid = 1; p1_addr = 32'h20; p1_wr_en = 0;
    tick();
    n_total++; if ({rr_p1_ready, rr_p0_ready} !== 2'b01) $display("FAIL both_first: got %b want 01", {rr_p1_ready, rr_p0_ready}); else n_pass++;
    n_total++; if (rr_req_addr !== 32'h10) $display("FAIL both_addr0: got %0h want 10", rr_req_addr); else n_pass++;
    p0_valid = 0;
    res_rd_data = 32'hAAAA_0000; res_code = 2'd1;
    tick();
    n_total++; if ({rr_p1_res_valid, rr_p0_res_valid, rr_p1_ready} !== 3'b010) $display("FAIL both_resp0: got %b want 010", {rr_p1_res_valid, rr_p0_res_valid, rr_p1_ready}); else n_pass++;
    n_total++; if (rr_p0_res_rd_data !== 32'hAAAA_0000) $display("FAIL both_rd0: got %0h want aaaa0000", rr_p0_res_rd_data); else n_pass++;
    tick();
    n_total++; if ({rr_p1_ready, rr_p0_ready} !== 2'b10) $display("FAIL both_second: got %b want 10", {rr_p1_ready, rr_p0_ready}); else n_pass++;
    n_total++; if (rr_req_addr !== 32'h20) $display("FAIL both_addr1: got %0h want 20", rr_req_addr); else n_pass++;
    n_total++; if (fx_p1_ready !== 1'b1) $display("FAIL both_fx_second: got %0b want 1", fx_p1_ready); else n_pass++;
    p1_valid = 0;
    res_rd_data = 32'hBBBB_0001; res_code = 2'd3;
    tick();
    n_total++; if ({rr_p1_res_valid, rr_p0_res_valid} !== 2'b10) $display("FAIL both_resp1: got %b want 10", {rr_p1_res_valid, rr_p0_res_valid}); else n_pass++;
    n_total++; if ({rr_p1_res_rd_data, rr_p1_res_code} !== {32'hBBBB_0001, 2'd3}) $display("FAIL both_rd1: got %0h/%0d want bbbb0001/3", rr_p1_res_rd_data, rr_p1_res_code); else n_pass++;
    tick();
  endtask

  // Response passthrough to port 1; port 0's held response stays put.
  task automatic test_passthrough();
    p1_valid = 1; p1_addr = 32'h30; p1_wr_en = 0;
    tick();
    res_rd_data = 32'h1234_5678; res_code = 2'd2;
    p1_valid = 0;
    tick();
    n_total++; if (rr_p1_res_valid !== 1'b1) $display("FAIL pt_resv1: got %0b want 1", rr_p1_res_valid); else n_pass++;
    n_total++; if (rr_p1_res_rd_data !== 32'h1234_5678) $display("FAIL pt_rd1: got %0h want 12345678", rr_p1_res_rd_data); else n_pass++;
    n_total++; if (rr_p1_res_code !== 2'd2) $display("FAIL pt_code1: got %0d want 2", rr_p1_res_code); else n_pass++;
    n_total++; if (rr_p0_res_valid !== 1'b0) $display("FAIL pt_resv0: got %0b want 0", rr_p0_res_valid); else n_pass++;
    n_total++; if ({rr_p0_res_rd_data, rr_p0_res_code} !== {32'hAAAA_0000, 2'd1}) $display("FAIL pt_hold0: got %0h/%0d want aaaa0000/1", rr_p0_res_rd_data, rr_p0_res_code); else n_pass++;
    tick();
  endtask

  // Both ports held valid for six grants.
  task automatic test_round_robin();
    int rr_order[$];
    int fx0, fx1;
    int want;
    fx0 = 0; fx1 = 0;
    do_reset();
    p0_valid = 1; p0_addr = 32'h100; p0_wr_en = 0;
    p1_valid = 1; p1_addr = 32'h200; p1_wr_en = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (rr_p0_ready) rr_order.push_back(0);
      if (rr_p1_ready) rr_order.push_back(1);
      if (fx_p0_ready) fx0++;
      if (fx_p1_ready) fx1++;
    end
    p0_valid = 0; p1_valid = 0;
    n_total++; if (rr_order.size() !== 6) $display("FAIL rr_count: got %0d want 6", rr_order.size()); else n_pass++;
    for (int i = 0; i < 6; i++) begin
      want = i % 2;
      if (i < rr_order.size()) begin
        n_total++; if (rr_order[i] !== want) $display("FAIL rr_order[%0d]: got %0d want %0d", i, rr_order[i], want); else n_pass++;
      end
    end
    n_total++; if (fx0 !== 6) $display("FAIL fx_p0_grants: got %0d want 6", fx0); else n_pass++;
    n_total++; if (fx1 !== 0) $display("FAIL fx_p1_grants: got %0d want 0", fx1); else n_pass++;
    tick();
    tick();
  endtask

  // Reset mid-ISSUE of a port-1 write aborts it; held valid is re-issued.
  task automatic test_reset_issue();
    do_reset();
    p1_valid = 1; p1_addr = 32'h40; p1_wr_data = 32'h55; p1_wr_en = 1;
    tick();
    n_total++; if ({rr_p1_ready, rr_req_wr_en} !== 2'b11) $display("FAIL ri_issue: got %b want 11", {rr_p1_ready, rr_req_wr_en}); else n_pass++;
    aresetn = 1'b0;
    #1;
    n_total++; if ({rr_p1_ready, rr_req_wr_en, rr_req_addr, rr_req_wr_data} !== '0) $display("FAIL ri_outs_zero: got ready %0b we %0b addr %0h", rr_p1_ready, rr_req_wr_en, rr_req_addr); else n_pass++;
    tick();
    n_total++; if ({rr_p1_res_valid, rr_p0_res_valid} !== 2'b00) $display("FAIL ri_no_resv: got %b want 00", {rr_p1_res_valid, rr_p0_res_valid}); else n_pass++;
    aresetn = 1'b1;
    tick();
    n_total++; if ({rr_p1_ready, rr_req_wr_en} !== 2'b11) $display("FAIL ri_reissue: got %b want 11", {rr_p1_ready, rr_req_wr_en}); else n_pass++;
    n_total++; if (rr_req_addr !== 32'h40) $display("FAIL ri_addr: got %0h want 40", rr_req_addr); else n_pass++;
    p1_valid = 0; p1_wr_en = 0;
    tick();
    n_total++; if (rr_p1_res_valid !== 1'b1) $display("FAIL ri_resv: got %0b want 1", rr_p1_res_valid); else n_pass++;
    tick();
  endtask

  // Idle bus with noise on the response inputs.
  task automatic test_idle();
    p0_valid = 0; p1_valid = 0;
    for (int c = 0; c < 10; c++) begin
      res_rd_data = $urandom();
      res_code = 2'($urandom_range(0, 3));
      tick();
      n_total++; if ({rr_p0_ready, rr_p1_ready, rr_p0_res_valid, rr_p1_res_valid, rr_req_wr_en} !== 5'b0) $display("FAIL idle[%0d]: got %b want 00000", c, {rr_p0_ready, rr_p1_ready, rr_p0_res_valid, rr_p1_res_valid, rr_req_wr_en}); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_both_read();
    test_passthrough();
    test_round_robin();
    test_reset_issue();
    test_idle();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter PRIO_MODE, default 0: 0 = round-robin, 1 = fixed priority with port 0 winning.
REQ-002 clk  in  1  clock; all state updates on the rising edge.
REQ-003 aresetn  in  1  reset, asynchronous, active-low.
REQ-004 i_p0_valid / i_p1_valid  in  1  requester N has a pending request.
REQ-005 i_pN_addr  in  `ADDR_W  request byte address, for N = 0, 1.
REQ-006 i_pN_wr_data  in  `WORD_W  write data.
REQ-007 i_pN_wr_en  in  1  1 = write, 0 = read.
REQ-008 i_pN_count  in  `MEM_COUNT_W  access size code, passed through unchanged.
REQ-009 o_pN_ready  out  1  one-cycle pulse: request of port N has been accepted.
REQ-010 o_pN_res_valid  out  1  one-cycle pulse: response for port N is valid.
REQ-011 o_pN_res_rd_data  out  `WORD_W  read data returned to port N.
REQ-012 o_pN_res_code  out  `MEM_CODE_W  response code returned to port N.
REQ-013 o_req_addr, o_req_wr_data, o_req_wr_en, o_req_count  out  as above  shared peripheral request bus.
REQ-014 i_res_rd_data  in  `WORD_W  and  i_res_code  in  `MEM_CODE_W  shared response; combinational from the peripherals within the same cycle.

Function
REQ-015 The FSM SHALL have three states: IDLE, ISSUE, RESP.
REQ-016 In IDLE or RESP with any valid request: arbitrate, latch the winner's payload into bus registers, record the winner ID, and go to ISSUE; with no valid request, go to (or stay in) IDLE.
REQ-017 ISSUE SHALL last exactly one cycle: bus registers drive o_req_*, o_pN_ready of the winner is 1, and i_res_* is captured at the closing edge; the FSM then goes to RESP.
REQ-018 In RESP, the captured data and code SHALL appear on the winner's o_pN_res_* with o_pN_res_valid = 1 for exactly one cycle.
REQ-019 Latency: valid sampled at edge E gives ready in cycle E+1 and res_valid in cycle E+2; peak throughput is one transaction per two cycles.
REQ-020 Outside ISSUE, o_req_wr_en SHALL be 0 and o_req_addr, o_req_wr_data and o_req_count SHALL be 0, so no spurious peripheral write can occur.
REQ-021 o_pN_res_rd_data and o_pN_res_code SHALL hold their last value between responses; only res_valid qualifies them.
REQ-022 The non-winning port's ready and res_valid SHALL stay 0; the losing request remains pending.
REQ-023 Requester rule: payload held stable while valid and until ready; valid may drop or change the cycle after ready; the arbiter never samples a port during its own ISSUE cycle.
REQ-024 Round-robin mode, both valid: grant the port not granted last. Single valid: grant it regardless of the pointer.
REQ-025 The last-grant pointer SHALL update only on a grant.
REQ-026 Fixed mode: port 0 SHALL win every tie; port 1 may starve.
REQ-027 A request arriving during RESP SHALL be arbitrated in that same cycle (back-to-back operation).
REQ-028 Response code and data SHALL pass through unchanged; the arbiter never generates its own codes.

Reset
REQ-029 On aresetn low: state = IDLE, all outputs 0, and the last-grant pointer = port 1, so port 0 wins the first tie.
REQ-030 Reset during ISSUE or RESP SHALL abort the transaction with no res_valid; after release, pending valids are re-arbitrated from IDLE.

Structure
REQ-031 FSM state encodings and the PRIO_RR = 0 / PRIO_FIXED = 1 constants SHALL live in the shared memory-bus defines header alongside `ADDR_W, `WORD_W, `MEM_COUNT_W and `MEM_CODE_W.
REQ-032 The grant computation (valids, pointer, mode -> one-hot grant) SHALL be a combinational sub-module rr_arbiter_2; all state stays in mem_bus_arbiter.

Verification
REQ-033 Port 0 write 0xDEADBEEF to 0x00000008, port 1 idle -> o_req_wr_en = 1 for one cycle, in cycle E+1 only; o_p0_ready in E+1; o_p0_res_valid in E+2.
REQ-034 Both ports read at the same edge after reset -> port 0 is served first; port 1 gets ready 2 cycles later; the two res_valid pulses are 2 cycles apart, port 0 first.
REQ-035 Both ports hold valid for 6 transactions in round-robin mode -> grants alternate 0,1,0,1,0,1. In PRIO_MODE = 1 -> six port-0 grants, zero port-1 grants.
REQ-036 Peripheral returns rd_data 0x12345678 and code 2 during ISSUE -> the winner sees 0x12345678 and code 2 with res_valid; the other port's outputs are unchanged.
REQ-037 Assert aresetn low during ISSUE of a port 1 write -> no res_valid; all outputs 0; after release, a held port 1 valid is re-issued.
REQ-038 Idle bus for 10 cycles with random data on i_res_* -> o_req_wr_en stays 0 and no ready or res_valid pulses occur.
